sram_1r1w_param: RTL and testbench

SRAM_1R1W_PARAM -- requirements
Module: sram_1r1w_param

---
 rtl/sram_1r1w_param.sv | 203 ++++++++++++++++++++
 tb/tb_sram_1r1w_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_param.sv
// ---------------------------------------------------------------------------
// sram_1r1w_param
//   One-read / one-write synchronous SRAM with per-lane write mask, a
//   power-up zeroing sweep and a configurable (1 or 2 cycle) read latency.
//
//   After reset the memory is swept to zero, one address per clock. While
//   the sweep runs, READY is low and read/write requests are ignored. Once
//   the last address is written, READY goes high and normal operation
//   begins.
//
// Parameters
//   WIDTH   data word width (integer multiple of LANE_W)
//   DEPTH   number of words
//   ADDR_W  address width, 2**ADDR_W >= DEPTH
//   LANE_W  write-mask lane width
//   RD_LAT  read latency in cycles (1 or 2)
//
// Ports
//   CLK     clock, all state changes on rising edge
//   RESETN  asynchronous active-low reset
//   READY   high once the zeroing sweep has completed
//   RCEN    read enable, active low;  RA read address
//   WCEN    write enable, active low; WA write address, D write data
//   BWE     per-lane write enable, bit i covers D[i*LANE_W +: LANE_W]
//   Q       registered read data, holds between results
//   QVALID  high for exactly the cycle in which Q carries a new result
//
// Configuration macro
//   SRAM_BYPASS_EN  defined: a read colliding with a write to the same
//                   address returns the merged (written) word.
//                   undefined: such a read returns the pre-write contents.
// ---------------------------------------------------------------------------
module sram_1r1w_param #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11,
  parameter int LANE_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  output logic                      READY,
  input  logic                      RCEN,
  input  logic [ADDR_W-1:0]         RA,
  input  logic                      WCEN,
  input  logic [ADDR_W-1:0]         WA,
  input  logic [WIDTH-1:0]          D,
  input  logic [WIDTH/LANE_W-1:0]   BWE,
  output logic [WIDTH-1:0]          Q,
  output logic                      QVALID
);

  localparam int LANES = WIDTH / LANE_W;
  // One extra bit so the range compare also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("sram_1r1w_param: RD_LAT must be 1 or 2");
  end

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] init_cnt_reg;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              run;
  logic              init_we;
  logic              wa_ok;
  logic              ra_ok;
  logic              wr_en;
  logic              rd_en;

  assign run     = (state_reg == ST_RUN);
  // Gated by RESETN so that clock edges during reset never touch memory.
  assign init_we = (state_reg == ST_INIT) && RESETN;
  assign wa_ok   = ({1'b0, WA} < DEPTH_X);
  assign ra_ok   = ({1'b0, RA} < DEPTH_X);
  assign wr_en   = run && !WCEN && wa_ok;
  assign rd_en   = run && !RCEN;
  assign READY   = run;

  // Sweep controller: INIT walks the counter 0..DEPTH-1, then RUN forever.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else if (state_reg == ST_INIT) begin
      if (init_cnt_reg == LAST_ADDR) begin
        state_reg <= ST_RUN;
      end else begin
        init_cnt_reg <= init_cnt_reg + 1'b1;
      end
    end
  end

  // Write port: sweep zeroes, or lane-masked update in RUN.
  always_ff @(posedge CLK) begin
    if (init_we) begin
      mem[init_cnt_reg] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (BWE[i]) begin
          mem[WA][i*LANE_W +: LANE_W] <= D[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read port: registered array read (read-first on collision), plus side
  // information needed to finish the result one stage later.
  logic [WIDTH-1:0] rd_raw_reg;
  logic             rd_oob_reg;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] s0_word;

`ifdef SRAM_BYPASS_EN
  logic             byp_hit_reg;
  logic [WIDTH-1:0] byp_d_reg;
  logic [LANES-1:0] byp_bwe_reg;

  always_ff @(posedge CLK) begin
    if (rd_en) begin
      rd_raw_reg  <= mem[RA];
      rd_oob_reg  <= !ra_ok;
      byp_hit_reg <= wr_en && (WA == RA);
      byp_d_reg   <= D;
      byp_bwe_reg <= BWE;
    end
  end

  // Write-through: written lanes come from D, the rest from the old word.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_byp
    assign rd_word[gi*LANE_W +: LANE_W] = (byp_hit_reg && byp_bwe_reg[gi]) ?
                                          byp_d_reg[gi*LANE_W +: LANE_W] :
                                          rd_raw_reg[gi*LANE_W +: LANE_W];
  end
`else
  always_ff @(posedge CLK) begin
    if (rd_en) begin
      rd_raw_reg <= mem[RA];
      rd_oob_reg <= !ra_ok;
    end
  end

  assign rd_word = rd_raw_reg;
`endif

  assign s0_word = rd_oob_reg ? '0 : rd_word;

  // Read pipeline valid bits and output register.
  logic             v0_reg;
  logic             out_v;
  logic [WIDTH-1:0] out_word;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      v0_reg <= 1'b0;
    end else begin
      v0_reg <= rd_en;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic             v1_reg;
    logic [WIDTH-1:0] s1_word_reg;

    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        v1_reg <= 1'b0;
      end else begin
        v1_reg <= v0_reg;
      end
    end

    always_ff @(posedge CLK) begin
      if (v0_reg) begin
        s1_word_reg <= s0_word;
      end
    end

    assign out_v    = v1_reg;
    assign out_word = s1_word_reg;
  end else begin : g_lat1
    assign out_v    = v0_reg;
    assign out_word = s0_word;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      Q      <= '0;
      QVALID <= 1'b0;
    end else begin
      QVALID <= out_v;
      if (out_v) begin
        Q <= out_word;
      end
    end
  end

endmodule

// File: tb/tb_sram_1r1w_param.sv
// ---------------------------------------------------------------------------
// tb_sram_1r1w_param
//   Two instances share one stimulus stream:
//     dut_a: DEPTH=12 (addresses 12..15 out of range), RD_LAT=2
//     dut_b: DEPTH=16 (full address space),            RD_LAT=1
//   A behavioural model (word arrays plus a result delay line per instance)
//   predicts READY, QVALID and Q after every clock edge.
// ---------------------------------------------------------------------------
module tb_sram_1r1w_param;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rcen;
  logic        wcen;
  logic [3:0]  ra;
  logic [3:0]  wa;
  logic [31:0] d;
  logic [3:0]  bwe;
  logic        ready_a, qvalid_a, ready_b, qvalid_b;
  logic [31:0] q_a, q_b;

  always #5 clk = ~clk;

  sram_1r1w_param #(.WIDTH(32), .DEPTH(12), .ADDR_W(4), .LANE_W(8), .RD_LAT(2)) dut_a (
    .CLK(clk), .RESETN(resetn), .READY(ready_a), .RCEN(rcen), .RA(ra),
    .WCEN(wcen), .WA(wa), .D(d), .BWE(bwe), .Q(q_a), .QVALID(qvalid_a)
  );

  sram_1r1w_param #(.WIDTH(32), .DEPTH(16), .ADDR_W(4), .LANE_W(8), .RD_LAT(1)) dut_b (
    .CLK(clk), .RESETN(resetn), .READY(ready_b), .RCEN(rcen), .RA(ra),
    .WCEN(wcen), .WA(wa), .D(d), .BWE(bwe), .Q(q_b), .QVALID(qvalid_b)
  );

  int tests = 0;
  int fails = 0;

  int          depth_m [2] = '{12, 16};
  int          lat_m   [2] = '{2, 1};
  logic [31:0] mem_m   [2][16];
  logic        pv      [2][2];
  logic [31:0] pd      [2][2];
  logic [31:0] exp_q   [2];
  logic        exp_qv  [2];
  int          edge_n;

`ifdef SRAM_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] COLL_EXP = 32'h0;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    check("ready_a",  {31'b0, ready_a},  {31'b0, edge_n >= depth_m[0]});
    check("ready_b",  {31'b0, ready_b},  {31'b0, edge_n >= depth_m[1]});
    check("qvalid_a", {31'b0, qvalid_a}, {31'b0, exp_qv[0]});
    check("qvalid_b", {31'b0, qvalid_b}, {31'b0, exp_qv[1]});
    check("q_a", q_a, exp_q[0]);
    check("q_b", q_b, exp_q[1]);
  endtask

  // One rising edge of the reference: edges 1..DEPTH after reset release
  // belong to the sweep (edge n zeroes address n-1); later edges are RUN.
  task automatic model_edge();
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      bit          run;
      logic        nv, ov;
      logic [31:0] nd, od;
      run = (edge_n > depth_m[i]);
      nv  = 1'b0;
      nd  = '0;
      if (run && !rcen) begin
        nv = 1'b1;
        if (int'(ra) < depth_m[i]) begin
          nd = mem_m[i][ra];
`ifdef SRAM_BYPASS_EN
          if (!wcen && wa == ra) nd = merge(nd, d, bwe);
`endif
        end
      end
      if (!run) begin
        mem_m[i][edge_n-1] = '0;
      end else if (!wcen && int'(wa) < depth_m[i]) begin
        mem_m[i][wa] = merge(mem_m[i][wa], d, bwe);
      end
      ov = pv[i][0];
      od = pd[i][0];
      if (lat_m[i] == 2) begin
        pv[i][0] = pv[i][1];
        pd[i][0] = pd[i][1];
        pv[i][1] = nv;
        pd[i][1] = nd;
      end else begin
        pv[i][0] = nv;
        pd[i][0] = nd;
      end
      exp_qv[i] = ov;
      if (ov) exp_q[i] = od;
    end
  endtask

  task automatic step(input logic rc, input logic [3:0] r, input logic wc, input logic [3:0] w,
                      input logic [31:0] dd, input logic [3:0] m);
    rcen = rc; ra = r; wcen = wc; wa = w; d = dd; bwe = m;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 4'd0, 1'b1, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, a, 1'b1, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] dd, input logic [3:0] m);
    step(1'b1, 4'd0, 1'b0, a, dd, m);
  endtask

  task automatic rand_steps(input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0] r, w;
      r = 4'($urandom_range(0, 15));
      w = ($urandom_range(0, 3) == 0) ? r : 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 2) == 0), r, 1'($urandom_range(0, 2) == 0), w,
           $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  // Assert reset mid-cycle, optionally check the asynchronous clear before
  // any edge, hold for some edges, then release just after a rising edge.
  task automatic do_reset(input bit async_chk, input int hold);
    #2;
    resetn = 1'b0;
    rcen   = 1'b1;
    wcen   = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      pv[i][0] = 1'b0; pv[i][1] = 1'b0;
      exp_q[i] = '0;   exp_qv[i] = 1'b0;
    end
    #1;
    if (async_chk) check_all();
    repeat (hold) @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; rcen = 1'b1; wcen = 1'b1; ra = '0; wa = '0; d = '0; bwe = '0;
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 16; a++) mem_m[i][a] = '0;
      pv[i][0] = 1'b0; pv[i][1] = 1'b0; pd[i][0] = '0; pd[i][1] = '0;
      exp_q[i] = '0; exp_qv[i] = 1'b0;
    end

    do_reset(1'b0, 3);

    // Requests during the sweep are ignored; READY rises after 12 / 16 edges.
    rand_steps(12);
    idle(4);
    check("ready_b_after_16", {31'b0, ready_b}, 32'd1);

    // Every address reads back zero, one result per cycle.
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(2);

    // Latency-2 timing and hold behaviour on dut_a.
    wr(4'd3, 32'hA5A5A5A5, 4'hF);
    rd(4'd3);
    idle(1);
    check("lat2_not_yet", {31'b0, qvalid_a}, 32'd0);
    idle(1);
    check("lat2_valid", {31'b0, qvalid_a}, 32'd1);
    check("lat2_data", q_a, 32'hA5A5A5A5);
    idle(1);
    check("lat2_hold_valid", {31'b0, qvalid_a}, 32'd0);
    check("lat2_hold_data", q_a, 32'hA5A5A5A5);

    // Single-lane masked write.
    wr(4'd5, 32'h11111111, 4'hF);
    wr(4'd5, 32'hFFFFFFFF, 4'h1);
    rd(4'd5);
    idle(2);
    check("mask_a", q_a, 32'h111111FF);
    check("mask_b", q_b, 32'h111111FF);

    // All-zero mask leaves memory unchanged.
    wr(4'd3, 32'h0, 4'h0);
    rd(4'd3);
    idle(2);
    check("bwe_zero", q_a, 32'hA5A5A5A5);

    // Same-address read/write collision.
    step(1'b0, 4'd7, 1'b0, 4'd7, 32'hDEADBEEF, 4'hF);
    idle(2);
    check("collide_a", q_a, COLL_EXP);
    check("collide_b", q_b, COLL_EXP);
    rd(4'd7);
    idle(2);
    check("after_collide", q_a, 32'hDEADBEEF);

    // Address 13 is out of range for dut_a only.
    wr(4'd13, 32'h12345678, 4'hF);
    rd(4'd13);
    idle(2);
    check("oob_read_a", q_a, 32'h0);
    check("inrange_read_b", q_b, 32'h12345678);
    for (int a = 0; a < 12; a++) rd(4'(a));
    idle(2);

    rand_steps(400);

    // Reset in RUN with reads in flight, then again part-way into the sweep.
    rd(4'd1);
    rd(4'd2);
    do_reset(1'b1, 2);
    idle(9);
    do_reset(1'b1, 1);
    idle(16);
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(2);

    rand_steps(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
